// File: rtl/pong_pkg.sv
// Purpose: shared types and constants for the pong match controller.
// Latency: n/a (types, constants and one pure function).
// Backpressure: n/a.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } match_state_t;

    // Encoding of the winner output.
    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_P1   = 2'b01;
    localparam logic [1:0] WINNER_P2   = 2'b10;

    // Saturating score increment: a score already at the limit never wraps.
    function automatic logic [3:0] sat_inc(input logic [3:0] score, input logic [3:0] limit);
        return (score >= limit) ? limit : score + 4'd1;
    endfunction

endpackage

// File: rtl/match_timer.sv
// Purpose: loadable down-counter with decrement enable and a zero flag.
// Latency: a load or decrement shows up on zero_o one clk later.
// Backpressure: none; a load takes priority over a decrement, and the count stops at 0.
// Ports: clk, rst_n (async active-low), load_i/load_val_i, dec_i, zero_o.
module match_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/match_ctrl.sv
// Purpose: pong match sequencer (idle, serve delay, play, point flash, game over) with scoring.
// Latency: every output changes one clk after the qualifying tick or start edge.
// Backpressure: none; inputs are sampled every clk (start) or on tick (ball edges, timer).
// Ports: clk, reset (async active-low), tick, start, out_left, out_right ->
//        ball_en, serve_left, score_p1, score_p2, flash, winner.
module match_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE   = 9,
    parameter int SERVE_TICKS = 1000,
    parameter int POINT_TICKS = 500,
    parameter int TIMERWIDTH  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       out_left,
    input  logic       out_right,
    output logic       ball_en,
    output logic       serve_left,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic       flash,
    output logic [1:0] winner
);

    localparam logic [3:0]            WIN_LIM    = 4'(WIN_SCORE);
    localparam logic [TIMERWIDTH-1:0] SERVE_LOAD = TIMERWIDTH'(SERVE_TICKS - 1);
    localparam logic [TIMERWIDTH-1:0] POINT_LOAD = TIMERWIDTH'(POINT_TICKS - 1);

    match_state_t    state_q;
    logic            start_prev_q;
    logic            ball_en_q;
    logic            serve_left_q;
    logic [3:0]      score_p1_q;
    logic [3:0]      score_p2_q;
    logic            flash_q;
    logic [1:0]      winner_q;

    logic                  start_rise;
    logic                  game_over;
    logic                  timer_zero;
    logic                  timer_load;
    logic                  timer_dec;
    logic [TIMERWIDTH-1:0] timer_val;

    assign start_rise = start && !start_prev_q;
    assign game_over  = (score_p1_q == WIN_LIM) || (score_p2_q == WIN_LIM);

    // Timer control mirrors the transitions below: every entry into SERVE or
    // POINT reloads the timer; SERVE/POINT count down on tick until zero.
    always_comb begin
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        timer_val  = SERVE_LOAD;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                timer_load = start_rise;
            end
            ST_SERVE: begin
                timer_dec = tick && !timer_zero;
            end
            ST_PLAY: begin
                if (tick && (out_left || out_right)) begin
                    timer_load = 1'b1;
                    timer_val  = (out_left && out_right) ? SERVE_LOAD : POINT_LOAD;
                end
            end
            ST_POINT: begin
                timer_dec  = tick && !timer_zero;
                timer_load = tick && timer_zero && !game_over;
            end
            default: begin
                timer_load = 1'b0;
            end
        endcase
    end

    match_timer #(
        .WIDTH (TIMERWIDTH)
    ) u_timer (
        .clk        (clk),
        .rst_n      (reset),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .dec_i      (timer_dec),
        .zero_o     (timer_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            // Held at 1 so a start button already pressed at reset release is not an edge.
            start_prev_q <= 1'b1;
            ball_en_q    <= 1'b0;
            serve_left_q <= 1'b0;
            score_p1_q   <= 4'd0;
            score_p2_q   <= 4'd0;
            flash_q      <= 1'b0;
            winner_q     <= WINNER_NONE;
        end else begin
            start_prev_q <= start;
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    if (start_rise) begin
                        score_p1_q <= 4'd0;
                        score_p2_q <= 4'd0;
                        winner_q   <= WINNER_NONE;
                        state_q    <= ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    if (tick && timer_zero) begin
                        ball_en_q <= 1'b1;
                        state_q   <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (tick) begin
                        if (out_left && out_right) begin
                            // Ambiguous exit: replay the serve without scoring.
                            ball_en_q <= 1'b0;
                            state_q   <= ST_SERVE;
                        end else if (out_left) begin
                            score_p2_q   <= sat_inc(score_p2_q, WIN_LIM);
                            serve_left_q <= 1'b1;
                            ball_en_q    <= 1'b0;
                            flash_q      <= 1'b1;
                            state_q      <= ST_POINT;
                        end else if (out_right) begin
                            score_p1_q   <= sat_inc(score_p1_q, WIN_LIM);
                            serve_left_q <= 1'b0;
                            ball_en_q    <= 1'b0;
                            flash_q      <= 1'b1;
                            state_q      <= ST_POINT;
                        end
                    end
                end
                ST_POINT: begin
                    if (tick && timer_zero) begin
                        flash_q <= 1'b0;
                        if (game_over) begin
                            winner_q <= (score_p1_q == WIN_LIM) ? WINNER_P1 : WINNER_P2;
                            state_q  <= ST_OVER;
                        end else begin
                            state_q  <= ST_SERVE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ball_en    = ball_en_q;
    assign serve_left = serve_left_q;
    assign score_p1   = score_p1_q;
    assign score_p2   = score_p2_q;
    assign flash      = flash_q;
    assign winner     = winner_q;

endmodule

// File: tb/tb_match_ctrl.sv
// Purpose: directed self-checking bench for match_ctrl (WIN_SCORE=3, SERVE_TICKS=4, POINT_TICKS=2).
// Latency: outputs are sampled on the falling clk edge after the qualifying rising edge.
// Backpressure: n/a; tick is pulsed for one clk out of every three.
module tb_match_ctrl;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       start;
    logic       out_left;
    logic       out_right;
    logic       ball_en;
    logic       serve_left;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic       flash;
    logic [1:0] winner;

    int n_checks = 0;
    int n_errors = 0;

    match_ctrl #(
        .WIN_SCORE   (3),
        .SERVE_TICKS (4),
        .POINT_TICKS (2),
        .TIMERWIDTH  (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .start      (start),
        .out_left   (out_left),
        .out_right  (out_right),
        .ball_en    (ball_en),
        .serve_left (serve_left),
        .score_p1   (score_p1),
        .score_p2   (score_p2),
        .flash      (flash),
        .winner     (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One game tick: high for one clk, then two idle clks (period 3 clk).
    task automatic game_tick();
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic press_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(negedge clk);
    endtask

    // From SERVE: SERVE_TICKS ticks release the ball.
    task automatic to_play();
        repeat (4) game_tick();
    endtask

    // Ball exits on one side, then the point flash runs its two ticks.
    task automatic score_point(input logic left);
        out_left  = left;
        out_right = !left;
        game_tick();
        out_left  = 1'b0;
        out_right = 1'b0;
        repeat (2) game_tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ball_en"}, ball_en, 0);
        check({tag, " serve_left"}, serve_left, 0);
        check({tag, " score_p1"}, score_p1, 0);
        check({tag, " score_p2"}, score_p2, 0);
        check({tag, " flash"}, flash, 0);
        check({tag, " winner"}, winner, 0);
    endtask

    initial begin
        reset     = 1'b0;
        tick      = 1'b0;
        start     = 1'b1;
        out_left  = 1'b0;
        out_right = 1'b0;

        // Reset state, with start held high through release.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        repeat (6) game_tick();
        check("start held thru reset ball_en", ball_en, 0);
        start = 1'b0;
        repeat (5) game_tick();
        check("idle no start ball_en", ball_en, 0);

        // Start -> SERVE; ball released after exactly 4 ticks.
        press_start();
        check("serve score_p1", score_p1, 0);
        check("serve score_p2", score_p2, 0);
        repeat (3) game_tick();
        check("serve 3 ticks ball_en", ball_en, 0);
        game_tick();
        check("serve 4 ticks ball_en", ball_en, 1);

        // Start edge during PLAY is ignored.
        press_start();
        check("play start ball_en", ball_en, 1);
        check("play start score_p1", score_p1, 0);

        // Left exit: point to player 2, flash for two ticks.
        out_left = 1'b1;
        game_tick();
        out_left = 1'b0;
        check("left pt score_p2", score_p2, 1);
        check("left pt score_p1", score_p1, 0);
        check("left pt serve_left", serve_left, 1);
        check("left pt flash", flash, 1);
        check("left pt ball_en", ball_en, 0);
        press_start();
        check("point start score_p2", score_p2, 1);
        check("point start flash", flash, 1);
        game_tick();
        check("flash tick1", flash, 1);
        game_tick();
        check("flash tick2 off", flash, 0);
        repeat (3) game_tick();
        check("after point serve ball_en", ball_en, 0);
        game_tick();
        check("after point play ball_en", ball_en, 1);

        // Both edges on one tick: re-serve without scoring.
        out_left  = 1'b1;
        out_right = 1'b1;
        game_tick();
        out_left  = 1'b0;
        out_right = 1'b0;
        check("both ball_en", ball_en, 0);
        check("both flash", flash, 0);
        check("both score_p1", score_p1, 0);
        check("both score_p2", score_p2, 1);
        check("both serve_left", serve_left, 1);
        to_play();
        check("both replay ball_en", ball_en, 1);

        // Three right exits: player 1 wins.
        for (int i = 0; i < 3; i++) begin
            out_right = 1'b1;
            game_tick();
            out_right = 1'b0;
            check($sformatf("right pt%0d score_p1", i), score_p1, i + 1);
            check($sformatf("right pt%0d serve_left", i), serve_left, 0);
            repeat (2) game_tick();
            if (i < 2) to_play();
        end
        check("p1 win winner", winner, 1);
        check("p1 win ball_en", ball_en, 0);
        check("p1 win flash", flash, 0);
        repeat (2) game_tick();
        check("over hold score_p1", score_p1, 3);
        check("over hold winner", winner, 1);

        // Restart from OVER.
        press_start();
        check("restart score_p1", score_p1, 0);
        check("restart score_p2", score_p2, 0);
        check("restart winner", winner, 0);
        to_play();
        check("restart play ball_en", ball_en, 1);

        // Reach 2/1 in PLAY, then abort with reset between clock edges.
        score_point(1'b0);
        to_play();
        score_point(1'b0);
        to_play();
        score_point(1'b1);
        to_play();
        check("pre-abort score_p1", score_p1, 2);
        check("pre-abort score_p2", score_p2, 1);
        check("pre-abort ball_en", ball_en, 1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_all_zero("abort");
        @(negedge clk) reset = 1'b1;
        repeat (5) game_tick();
        check("post-abort idle ball_en", ball_en, 0);

        // Player 2 wins from a fresh match.
        press_start();
        to_play();
        for (int i = 0; i < 3; i++) begin
            score_point(1'b1);
            if (i < 2) to_play();
        end
        check("p2 win score_p2", score_p2, 3);
        check("p2 win winner", winner, 2);
        check("p2 win serve_left", serve_left, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/match_ctrl.md
MATCH_CTRL -- requirements
Module: match_ctrl

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 9, points needed to win (range 1..15).
REQ-002 SHALL have parameter SERVE_TICKS, default 1000, game ticks the ball is held before release.
REQ-003 SHALL have parameter POINT_TICKS, default 500, game ticks the point-scored flash lasts.
REQ-004 SHALL have parameter TIMERWIDTH, default 16, tick timer width; must hold max(SERVE_TICKS, POINT_TICKS).
REQ-005 SHALL have port clk  in  1  single clock for all logic.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port tick  in  1  one-clk-wide game-tick enable.
REQ-008 SHALL have port start  in  1  start button, level, already debounced.
REQ-009 SHALL have port out_left  in  1  ball past left edge, level; point to player 2.
REQ-010 SHALL have port out_right  in  1  ball past right edge, level; point to player 1.
REQ-011 SHALL have port ball_en  out  1  ball motion enable to game logic.
REQ-012 SHALL have port serve_left  out  1  next serve travels toward left player.
REQ-013 SHALL have port score_p1  out  4  player 1 score, binary.
REQ-014 SHALL have port score_p2  out  4  player 2 score, binary.
REQ-015 SHALL have port flash  out  1  background-highlight request.
REQ-016 SHALL have port winner  out  2  00 none, 01 player 1, 10 player 2.

Function
REQ-017 SHALL implement the FSM states IDLE, SERVE, PLAY, POINT, OVER; all outputs registered.
REQ-018 SHALL detect start rising edges every clk via a registered previous value; rising edges outside IDLE/OVER are ignored.
REQ-019 IDLE: on a start rising edge, clear both scores and winner, load timer with SERVE_TICKS-1, and go to SERVE.
REQ-020 SERVE: ball_en=0; the timer decrements only on tick; a tick at timer==0 goes to PLAY.
REQ-021 PLAY: ball_en=1; out_left/out_right are sampled only on tick.
REQ-022 PLAY, tick with out_left only: score_p2+1, serve_left=1, timer=POINT_TICKS-1, go to POINT.
REQ-023 PLAY, tick with out_right only: score_p1+1, serve_left=0, timer=POINT_TICKS-1, go to POINT.
REQ-024 PLAY, tick with both asserted: no score change, serve_left unchanged, timer=SERVE_TICKS-1, go to SERVE (re-serve).
REQ-025 POINT: ball_en=0, flash=1; a tick at timer==0 goes to OVER if either score equals WIN_SCORE, else reloads SERVE_TICKS-1 and goes to SERVE.
REQ-026 OVER: ball_en=0, flash=0; winner=01 if score_p1==WIN_SCORE, else 10; scores hold.
REQ-027 OVER: on a start rising edge, clear scores and winner, reload SERVE_TICKS-1, and go to SERVE.
REQ-028 Scores SHALL saturate at WIN_SCORE and never wrap.
REQ-029 Latency: an output change SHALL be visible the clk after the qualifying edge (tick or start).
REQ-030 A timer value of 0 after load (parameter 1) SHALL leave the state on the next tick.

Reset
REQ-031 Asserting reset (low) SHALL asynchronously force: state IDLE, timer 0, ball_en 0, serve_left 0, scores 0, flash 0, winner 00.
REQ-032 Reset SHALL set the start-edge register to 1, so a start held through reset release does not start a match.
REQ-033 Reset asserted mid-match SHALL abort immediately, with no score retained.

Structure
REQ-034 The shared package pong_pkg SHALL hold the state enum (match_state_t) and the winner encoding constants.
REQ-035 SHALL contain one sub-module, match_timer: a loadable down-counter with tick enable and a zero flag.

Verification (overrides WIN_SCORE=3, SERVE_TICKS=4, POINT_TICKS=2, tick every 3 clk)
REQ-036 Start pulse from IDLE -> SERVE, ball_en rises after exactly 4 ticks, scores 0/0.
REQ-037 In PLAY, out_left held over 1 tick -> score_p2=1, serve_left=1, flash=1 for 2 ticks, then SERVE.
REQ-038 out_left and out_right together on one tick -> scores unchanged, SERVE re-entered, flash stays 0.
REQ-039 Three out_right points -> score_p1=3, winner=01 after POINT, ball_en=0; start edge -> scores 0/0, winner 00, SERVE.
REQ-040 start held high across reset release -> stays IDLE; reset pulsed low in PLAY with score 2/1 -> all outputs 0 immediately.
REQ-041 start edge during PLAY and POINT -> no state or score change.
